// File: rtl/vending_machine.sv
// Single-product vending controller: price 3 units, accepts 1- and 2-unit coins.
// Latency: the coin completing the price is sampled at edge N; x/y pulse for one cycle from edge N.
// Backpressure: none; one decoded coin per clock is always accepted, and outputs are one-cycle pulses.
//
// Ports:
//   clk    - system clock, all state changes on rising edge
//   rst_n  - synchronous reset, ACTIVE-HIGH despite the suffix (1 at a rising edge clears)
//   i      - coin-present bit of coin code {i,j}
//   j      - coin-value bit of coin code {i,j} (1 = 2-unit coin)
//   x      - dispense pulse, registered
//   y      - change pulse (1 unit), registered, coincident with x
//
// Configuration macro: VENDING_MACHINE_CHANGE_EN
//   defined     : a 4-unit overpay pulses y together with x
//   not defined : y tied to 0; the overpay still vends and the excess unit is forfeited
module vending_machine (
  input  logic clk,
  input  logic rst_n,
  input  logic i,
  input  logic j,
  output logic x,
  output logic y
);

  // Credit held so far; encoding 3 is never entered but is recovered to S0.
  typedef enum logic [1:0] {
    S0     = 2'd0,
    S1     = 2'd1,
    S2     = 2'd2,
    S3_BAD = 2'd3
  } state_t;

  // Name is fixed: benches probe it hierarchically.
  state_t state;
  state_t w_state_nxt;

  logic w_coin_vld;   // 10 or 11; code 01 is treated as no coin
  logic w_coin_two;   // 11: 2-unit coin
  logic w_x_nxt;
  logic w_y_nxt;
  logic r_x;

  assign w_coin_vld = i;
  assign w_coin_two = i & j;

  always_comb begin
    w_state_nxt = state;
    w_x_nxt     = 1'b0;
    w_y_nxt     = 1'b0;
    case (state)
      S0: begin
        if (w_coin_vld) begin
          w_state_nxt = w_coin_two ? S2 : S1;
        end
      end
      S1: begin
        if (w_coin_vld) begin
          if (w_coin_two) begin
            w_state_nxt = S0;
            w_x_nxt     = 1'b1;
          end else begin
            w_state_nxt = S2;
          end
        end
      end
      S2: begin
        // Either coin reaches the price; a 2-unit coin overpays by one.
        if (w_coin_vld) begin
          w_state_nxt = S0;
          w_x_nxt     = 1'b1;
          w_y_nxt     = w_coin_two;
        end
      end
      default: begin
        // Unused encoding: drop back to empty credit without any pulse.
        w_state_nxt = S0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S0;
      r_x   <= 1'b0;
    end else begin
      state <= w_state_nxt;
      r_x   <= w_x_nxt;
    end
  end

  assign x = r_x;

`ifdef VENDING_MACHINE_CHANGE_EN
  logic r_y;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_y_nxt;
    end
  end

  assign y = r_y;
`else
  // Change path removed; the overpay request is intentionally dropped.
  logic w_y_unused;
  assign w_y_unused = w_y_nxt;
  assign y          = 1'b0;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine with a credit-sum reference model and an
// expected-result queue; each driven cycle pushes {state,x,y} and the post-edge
// sample pops and compares it.
module tb_vending_machine;

`ifdef VENDING_MACHINE_CHANGE_EN
  localparam bit CHANGE_EN = 1'b1;
`else
  localparam bit CHANGE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic i;
  logic j;
  logic x;
  logic y;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integer credit.
  int credit = 0;

  typedef struct {
    string    tag;
    logic [1:0] st;
    logic     ex;
    logic     ey;
  } exp_t;

  exp_t sb_q[$];

  vending_machine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .j     (j),
    .x     (x),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, predict, advance past the edge, compare.
  task automatic cyc(input string tag, input logic rr, input logic ii, input logic jj);
    exp_t e;
    exp_t g;
    int   val;
    rst_n = rr;
    i     = ii;
    j     = jj;
    e.tag = tag;
    e.ex  = 1'b0;
    e.ey  = 1'b0;
    if (rr) begin
      credit = 0;
    end else begin
      val = ii ? (jj ? 2 : 1) : 0;
      if (val != 0) begin
        credit = credit + val;
        if (credit >= 3) begin
          e.ex   = 1'b1;
          e.ey   = (credit == 4) && CHANGE_EN;
          credit = 0;
        end
      end
    end
    e.st = 2'(credit);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    g = sb_q.pop_front();

    checks++;
    assert (dut.state === g.st) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", g.tag, dut.state, g.st);
    end
    checks++;
    assert (x === g.ex) else begin
      errors++;
      $error("FAIL %s x: got %b want %b", g.tag, x, g.ex);
    end
    checks++;
    assert (y === g.ey) else begin
      errors++;
      $error("FAIL %s y: got %b want %b", g.tag, y, g.ey);
    end
  endtask

  initial begin
    int x_hi_cnt;
    int last_x_cyc;
    rst_n = 1'b1;
    i     = 1'b0;
    j     = 1'b0;
    #2;

    // Reset held, then idle
    cyc("rst0", 1'b1, 1'b0, 1'b0);
    cyc("rst1", 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cyc("idle_after_rst", 1'b0, 1'b0, 1'b0);

    // 1,1,1 separated by idle cycles
    cyc("c1a", 1'b0, 1'b1, 1'b0);
    cyc("idle", 1'b0, 1'b0, 1'b0);
    cyc("c1b", 1'b0, 1'b1, 1'b0);
    cyc("idle", 1'b0, 1'b0, 1'b0);
    cyc("c1c_vend", 1'b0, 1'b1, 1'b0);
    cyc("post_vend", 1'b0, 1'b0, 1'b0);

    // 2 then 1; then 1 then 2
    cyc("c2", 1'b0, 1'b1, 1'b1);
    cyc("c1_vend", 1'b0, 1'b1, 1'b0);
    cyc("idle", 1'b0, 1'b0, 1'b0);
    cyc("c1", 1'b0, 1'b1, 1'b0);
    cyc("c2_vend", 1'b0, 1'b1, 1'b1);
    cyc("idle", 1'b0, 1'b0, 1'b0);

    // 2 then 2: overpay
    cyc("c2", 1'b0, 1'b1, 1'b1);
    cyc("c2_change", 1'b0, 1'b1, 1'b1);
    cyc("idle", 1'b0, 1'b0, 1'b0);

    // Invalid code in S1, then reset in S2 with a 2-unit coin
    cyc("c1", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc("inv01", 1'b0, 1'b0, 1'b1);
    cyc("c1_to_s2", 1'b0, 1'b1, 1'b0);
    cyc("rst_with_c2", 1'b1, 1'b1, 1'b1);
    cyc("idle_after_rst", 1'b0, 1'b0, 1'b0);

    // Back-to-back 2,2,2,1
    cyc("bb_c2a", 1'b0, 1'b1, 1'b1);
    cyc("bb_c2b_change", 1'b0, 1'b1, 1'b1);
    cyc("bb_c2c", 1'b0, 1'b1, 1'b1);
    cyc("bb_c1_vend", 1'b0, 1'b1, 1'b0);
    cyc("idle", 1'b0, 1'b0, 1'b0);

    // Long back-to-back 1-unit run: x must never be high two cycles in a row
    x_hi_cnt   = 0;
    last_x_cyc = -10;
    for (int k = 0; k < 9; k++) begin
      cyc("run1", 1'b0, 1'b1, 1'b0);
      if (x === 1'b1) begin
        checks++;
        assert (k - last_x_cyc >= 3) else begin
          errors++;
          $error("FAIL run1_spacing: got gap %0d want >=3", k - last_x_cyc);
        end
        last_x_cyc = k;
        x_hi_cnt++;
      end
    end
    checks++;
    assert (x_hi_cnt == 3) else begin
      errors++;
      $error("FAIL run1_vends: got %0d want %0d", x_hi_cnt, 3);
    end
    cyc("idle_end", 1'b0, 1'b0, 1'b0);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: got %0d want %0d", sb_q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
